// File: rtl/qsys_pwm_generator.sv
// qsys_pwm_generator: Avalon-MM slave PWM controller.
//   Drives one PWM output from the programmable PERIOD and DUTY registers.
//   Reloads are glitch-free and happen only at the end of a period. An
//   end-of-period flag raises a level interrupt, so software can retune
//   the duty once per period.
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   address    word select: 0 CTRL, 1 PERIOD, 2 DUTY, 3 STATUS
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   readdata   combinational read data, zero wait states
//   pwm_out    registered PWM output
//   irq        level interrupt = PEND & IRQ_EN
module qsys_pwm_generator #(
   parameter int unsigned WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        pwm_out,
   output logic        irq
);

   logic             en_q, en_d;
   logic             pol_q, pol_d;
   logic             irq_en_q, irq_en_d;
   logic [WIDTH-1:0] per_stg_q, per_stg_d;
   logic [WIDTH-1:0] duty_stg_q, duty_stg_d;
   logic [WIDTH-1:0] per_act_q, per_act_d;
   logic [WIDTH-1:0] duty_act_q, duty_act_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             pwm_q, pwm_d;

   logic wr_en, wr_ctrl, wr_per, wr_duty, wr_stat;
   logic run, terminal;

   assign wr_en   = chipselect & ~write_n;
   assign wr_ctrl = wr_en && (address == 2'd0);
   assign wr_per  = wr_en && (address == 2'd1);
   assign wr_duty = wr_en && (address == 2'd2);
   assign wr_stat = wr_en && (address == 2'd3);

   always_comb begin
      en_d       = en_q;
      pol_d      = pol_q;
      irq_en_d   = irq_en_q;
      per_stg_d  = per_stg_q;
      duty_stg_d = duty_stg_q;
      if (wr_ctrl) begin
         en_d     = writedata[0];
         pol_d    = writedata[1];
         irq_en_d = writedata[2];
      end
      if (wr_per) begin
         per_stg_d = writedata[WIDTH-1:0];
      end
      if (wr_duty) begin
         duty_stg_d = writedata[WIDTH-1:0];
      end
   end

   // Counting needs EN both before and after this edge. A write that clears EN
   // therefore stops the counter, output and PEND on the very next cycle. A
   // write that sets EN starts counting one cycle later, from cnt=0, with the
   // staging values latched at the write.
   assign run      = en_q & en_d;
   assign terminal = (cnt_q == per_act_q);

   always_comb begin
      cnt_d      = '0;
      per_act_d  = per_stg_q;
      duty_act_d = duty_stg_q;
      if (run) begin
         if (terminal) begin
            cnt_d = '0;
         end else begin
            cnt_d      = cnt_q + WIDTH'(1);
            per_act_d  = per_act_q;
            duty_act_d = duty_act_q;
         end
      end
      pwm_d = (run & (cnt_q < duty_act_q)) ^ pol_d;
      // Setting PEND wins over a W1C in the same cycle.
      if (run && terminal) begin
         pend_d = 1'b1;
      end else if (wr_stat && writedata[0]) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q       <= 1'b0;
         pol_q      <= 1'b0;
         irq_en_q   <= 1'b0;
         per_stg_q  <= '0;
         duty_stg_q <= '0;
         per_act_q  <= '0;
         duty_act_q <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         pwm_q      <= 1'b0;
      end else begin
         en_q       <= en_d;
         pol_q      <= pol_d;
         irq_en_q   <= irq_en_d;
         per_stg_q  <= per_stg_d;
         duty_stg_q <= duty_stg_d;
         per_act_q  <= per_act_d;
         duty_act_q <= duty_act_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         pwm_q      <= pwm_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0: readdata[2:0] = {irq_en_q, pol_q, en_q};
         2'd1: readdata[WIDTH-1:0] = per_stg_q;
         2'd2: readdata[WIDTH-1:0] = duty_stg_q;
         default: readdata[0] = pend_q;
      endcase
   end

   assign pwm_out = pwm_q;
   assign irq     = pend_q & irq_en_q;

endmodule

// File: tb/tb_qsys_pwm_generator.sv
module tb_qsys_pwm_generator;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        pwm_out;
   logic        irq;

   int checks = 0;
   int errors = 0;

   qsys_pwm_generator #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .pwm_out    (pwm_out),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a period is a run of len cycles at positions
   // 0..len-1; the output is active while position < duty.
   logic [31:0] m_P = '0, m_D = '0;
   bit          m_en = 0, m_pol = 0, m_ie = 0, m_pend = 0, m_pwm = 0;
   longint      m_pos = 0, m_len = 1, m_duty = 0;

   always @(posedge clk or negedge reset_n) begin
      bit w, n_en, n_pol, n_ie, set;
      if (!reset_n) begin
         m_P = '0; m_D = '0; m_en = 0; m_pol = 0; m_ie = 0; m_pend = 0; m_pwm = 0;
         m_pos = 0; m_len = 1; m_duty = 0;
      end else begin
         w     = chipselect && !write_n;
         n_en  = m_en;
         n_pol = m_pol;
         n_ie  = m_ie;
         set   = 0;
         if (w && address == 2'd0) begin
            n_en  = writedata[0];
            n_pol = writedata[1];
            n_ie  = writedata[2];
         end
         if (m_en && n_en) begin
            m_pwm = (m_pos < m_duty) ^ n_pol;
            if (m_pos == m_len - 1) begin
               set    = 1;
               m_pend = 1;
               m_pos  = 0;
               m_len  = longint'(m_P) + 1;
               m_duty = longint'(m_D);
            end else begin
               m_pos++;
            end
         end else begin
            m_pwm  = n_pol;
            m_pos  = 0;
            m_len  = longint'(m_P) + 1;
            m_duty = longint'(m_D);
         end
         if (w && address == 2'd3 && writedata[0] && !set) m_pend = 0;
         if (w && address == 2'd1) m_P = writedata;
         if (w && address == 2'd2) m_D = writedata;
         m_en  = n_en;
         m_pol = n_pol;
         m_ie  = n_ie;
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         check("pwm_model", {31'd0, pwm_out}, {31'd0, m_pwm});
         check("irq_model", {31'd0, irq}, {31'd0, m_pend & m_ie});
      end
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      @(negedge clk);
      address = a;
      #1;
      check(name, readdata, exp);
   endtask

   task automatic count_hi(input int n, output int hi);
      hi = 0;
      repeat (n) begin
         @(negedge clk);
         hi += int'(pwm_out);
      end
   endtask

   task automatic wait_irq();
      int k = 0;
      while (irq !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("irq_wait", {31'd0, irq}, 32'd1);
   endtask

   initial begin
      int hi;
      int k;
      logic prev;
      reset_n = 1'b0;
      #3;
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         #1;
         check("reset_read", readdata, 32'd0);
      end
      check("reset_pwm", {31'd0, pwm_out}, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      #9 reset_n = 1'b1;

      // T1: P=9, D=3 -> 3 high of 10
      wr(2'd1, 32'd9);
      wr(2'd2, 32'd3);
      wr(2'd0, 32'd1);
      idle(12);
      count_hi(10, hi);
      check("t1_high_cycles", 32'(hi), 32'd3);
      rd(2'd3, 32'd1, "t1_pend");
      rd(2'd1, 32'd9, "t1_period_rd");
      rd(2'd2, 32'd3, "t1_duty_rd");
      rd(2'd0, 32'd1, "t1_ctrl_rd");

      // T2: duty write at cnt=5 only affects the next period
      k = 0;
      prev = pwm_out;
      @(negedge clk);
      while (!(pwm_out === 1'b1 && prev === 1'b0) && k < 30) begin
         prev = pwm_out;
         @(negedge clk);
         k++;
      end
      check("t2_rise", {31'd0, pwm_out}, 32'd1);
      hi = 1;
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         if (i == 4) begin
            address    = 2'd2;
            writedata  = 32'd7;
            chipselect = 1'b1;
            write_n    = 1'b0;
         end
         if (i == 5) begin
            chipselect = 1'b0;
            write_n    = 1'b1;
         end
         hi += int'(pwm_out);
      end
      check("t2_cur_period", 32'(hi), 32'd3);
      count_hi(10, hi);
      check("t2_next_period", 32'(hi), 32'd7);

      // T3: duty extremes and polarity
      wr(2'd2, 32'd0);
      idle(25);
      count_hi(10, hi);
      check("t3_d0", 32'(hi), 32'd0);
      wr(2'd2, 32'd10);
      idle(25);
      count_hi(10, hi);
      check("t3_d10", 32'(hi), 32'd10);
      wr(2'd0, 32'd3);
      idle(25);
      count_hi(10, hi);
      check("t3_d10_inv", 32'(hi), 32'd0);
      wr(2'd2, 32'd0);
      idle(25);
      count_hi(10, hi);
      check("t3_d0_inv", 32'(hi), 32'd10);
      wr(2'd0, 32'd1);
      wr(2'd2, 32'd3);
      idle(25);

      // T4: interrupt, W1C on the set cycle loses, later W1C clears
      wr(2'd0, 32'd5);
      wr(2'd3, 32'd1);
      wait_irq();
      idle(8);
      wr(2'd3, 32'd1);
      check("t4_set_wins", {31'd0, irq}, 32'd1);
      wr(2'd3, 32'd1);
      check("t4_cleared", {31'd0, irq}, 32'd0);

      // T5: P=0 -> period 1
      wr(2'd0, 32'd1);
      wr(2'd1, 32'd0);
      wr(2'd2, 32'd1);
      idle(25);
      count_hi(10, hi);
      check("t5_full", 32'(hi), 32'd10);
      wr(2'd3, 32'd1);
      rd(2'd3, 32'd1, "t5_pend_every_cycle");
      wr(2'd0, 32'd2);
      check("t5_dis_pol1", {31'd0, pwm_out}, 32'd1);
      wr(2'd0, 32'd0);
      check("t5_dis_pol0", {31'd0, pwm_out}, 32'd0);
      rd(2'd3, 32'd1, "t5_pend_kept");
      wr(2'd3, 32'd1);
      rd(2'd3, 32'd0, "t5_pend_clr");

      // T6: asynchronous reset mid-period
      wr(2'd1, 32'd9);
      wr(2'd2, 32'd3);
      wr(2'd0, 32'd5);
      wait_irq();
      idle(1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_pwm", {31'd0, pwm_out}, 32'd0);
      check("t6_irq", {31'd0, irq}, 32'd0);
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         #1;
         check("t6_read", readdata, 32'd0);
      end
      @(negedge clk);
      #2 reset_n = 1'b1;
      idle(3);
      check("t6_pwm_after", {31'd0, pwm_out}, 32'd0);
      rd(2'd1, 32'd0, "t6_period_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
